// File: rtl/dcache_req_arbiter.sv
// Round-robin arbiter sharing one multi-lane D$ port between several requesters.
// A grant stays locked until every valid lane of the request has been accepted.
//
// state  | meaning
// IDLE   | no request in flight; pick first active requester at/after rr_ptr
// LOCKED | grant_id owns the port until its remaining lanes are accepted
module dcache_req_arbiter #(
  parameter int NUM_REQS     = 2,
  parameter int NUM_LANES    = 4,
  parameter int ADDR_WIDTH   = 30,
  parameter int DATA_WIDTH   = 32,
  parameter int TAG_IN_WIDTH = 8,
  localparam int ID_BITS       = $clog2(NUM_REQS),
  localparam int BE_WIDTH      = DATA_WIDTH / 8,
  localparam int TAG_OUT_WIDTH = TAG_IN_WIDTH + ID_BITS
) (
  input  logic                                       clk,
  input  logic                                       reset,
  input  logic [NUM_REQS*NUM_LANES-1:0]              req_valid_in,
  input  logic [NUM_REQS*NUM_LANES-1:0]              req_rw_in,
  input  logic [NUM_REQS*NUM_LANES*ADDR_WIDTH-1:0]   req_addr_in,
  input  logic [NUM_REQS*NUM_LANES*BE_WIDTH-1:0]     req_byteen_in,
  input  logic [NUM_REQS*NUM_LANES*DATA_WIDTH-1:0]   req_data_in,
  input  logic [NUM_REQS*NUM_LANES*TAG_IN_WIDTH-1:0] req_tag_in,
  output logic [NUM_REQS*NUM_LANES-1:0]              req_ready_in,
  output logic [NUM_LANES-1:0]                       req_valid_out,
  output logic [NUM_LANES-1:0]                       req_rw_out,
  output logic [NUM_LANES*ADDR_WIDTH-1:0]            req_addr_out,
  output logic [NUM_LANES*BE_WIDTH-1:0]              req_byteen_out,
  output logic [NUM_LANES*DATA_WIDTH-1:0]            req_data_out,
  output logic [NUM_LANES*TAG_OUT_WIDTH-1:0]         req_tag_out,
  input  logic [NUM_LANES-1:0]                       req_ready_out,
  input  logic                                       rsp_valid_in,
  input  logic [NUM_LANES-1:0]                       rsp_tmask_in,
  input  logic [NUM_LANES*DATA_WIDTH-1:0]            rsp_data_in,
  input  logic [TAG_OUT_WIDTH-1:0]                   rsp_tag_in,
  output logic                                       rsp_ready_in,
  output logic [NUM_REQS-1:0]                        rsp_valid_out,
  output logic [NUM_LANES-1:0]                       rsp_tmask_out,
  output logic [NUM_LANES*DATA_WIDTH-1:0]            rsp_data_out,
  output logic [TAG_IN_WIDTH-1:0]                    rsp_tag_out,
  input  logic [NUM_REQS-1:0]                        rsp_ready_out
);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t                    state, state_next;
  logic [ID_BITS-1:0]        rr_ptr, rr_ptr_next;
  logic [ID_BITS-1:0]        grant_id, grant_id_next;
  logic [ID_BITS-1:0]        grant;
  logic                      grant_valid;
  logic [NUM_REQS-1:0]       active;
  logic [2*NUM_REQS-1:0]     active_rot;
  logic [NUM_LANES-1:0]      valid_g;
  logic                      complete;
  logic [ID_BITS-1:0]        rid;
  logic                      rid_ok;

  function automatic logic [ID_BITS-1:0] next_id(input logic [ID_BITS-1:0] id);
    return (32'(id) >= NUM_REQS - 1) ? '0 : id + 1'b1;
  endfunction

  always_comb begin
    for (int r = 0; r < NUM_REQS; r++)
      active[r] = |req_valid_in[r*NUM_LANES +: NUM_LANES];
  end

  // Rotating the doubled vector puts rr_ptr at bit 0; lowest set bit wins.
  always_comb begin
    active_rot  = {active, active} >> rr_ptr;
    grant       = grant_id;
    grant_valid = 1'b0;
    if (state == LOCKED) begin
      grant_valid = active[grant_id];
    end else begin
      for (int i = NUM_REQS - 1; i >= 0; i--) begin
        if (active_rot[i]) begin
          grant       = ID_BITS'((32'(rr_ptr) + i) % NUM_REQS);
          grant_valid = 1'b1;
        end
      end
    end
  end

  always_comb begin
    valid_g        = '0;
    req_rw_out     = '0;
    req_addr_out   = '0;
    req_byteen_out = '0;
    req_data_out   = '0;
    req_tag_out    = '0;
    req_ready_in   = '0;
    for (int r = 0; r < NUM_REQS; r++) begin
      if (grant_valid && grant == ID_BITS'(r)) begin
        valid_g        = req_valid_in[r*NUM_LANES +: NUM_LANES];
        req_rw_out     = req_rw_in[r*NUM_LANES +: NUM_LANES];
        req_addr_out   = req_addr_in[r*NUM_LANES*ADDR_WIDTH +: NUM_LANES*ADDR_WIDTH];
        req_byteen_out = req_byteen_in[r*NUM_LANES*BE_WIDTH +: NUM_LANES*BE_WIDTH];
        req_data_out   = req_data_in[r*NUM_LANES*DATA_WIDTH +: NUM_LANES*DATA_WIDTH];
        for (int l = 0; l < NUM_LANES; l++)
          req_tag_out[l*TAG_OUT_WIDTH +: TAG_OUT_WIDTH] =
            {req_tag_in[(r*NUM_LANES+l)*TAG_IN_WIDTH +: TAG_IN_WIDTH], ID_BITS'(r)};
        req_ready_in[r*NUM_LANES +: NUM_LANES] = req_ready_out;
      end
    end
    req_valid_out = valid_g;
  end

  assign complete = grant_valid && ((valid_g & ~req_ready_out) == '0);

  always_comb begin
    state_next    = state;
    rr_ptr_next   = rr_ptr;
    grant_id_next = grant_id;
    case (state)
      IDLE: begin
        if (grant_valid) begin
          if (complete) begin
            rr_ptr_next = next_id(grant);
          end else begin
            state_next    = LOCKED;
            grant_id_next = grant;
          end
        end
      end
      LOCKED: begin
        if (complete || !grant_valid) begin
          state_next  = IDLE;
          rr_ptr_next = next_id(grant_id);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      grant_id <= '0;
    end else begin
      state    <= state_next;
      rr_ptr   <= rr_ptr_next;
      grant_id <= grant_id_next;
    end
  end

  // Responses bypass the FSM entirely; an unknown id is swallowed.
  assign rid           = rsp_tag_in[ID_BITS-1:0];
  assign rid_ok        = (32'(rid) < NUM_REQS);
  assign rsp_ready_in  = rid_ok ? rsp_ready_out[rid] : 1'b1;
  assign rsp_tmask_out = rsp_tmask_in;
  assign rsp_data_out  = rsp_data_in;
  assign rsp_tag_out   = rsp_tag_in[TAG_OUT_WIDTH-1:ID_BITS];

  always_comb begin
    for (int r = 0; r < NUM_REQS; r++)
      rsp_valid_out[r] = rsp_valid_in && rid_ok && (rid == ID_BITS'(r));
  end

`ifndef SYNTHESIS
  logic [NUM_LANES-1:0] sent_lanes;

  always_ff @(posedge clk) begin
    if (reset)
      sent_lanes <= '0;
    else if (state_next == LOCKED)
      sent_lanes <= ((state == LOCKED) ? sent_lanes : '0) | (valid_g & req_ready_out);
    else
      sent_lanes <= '0;
  end

  always_ff @(posedge clk) begin
    if (!reset && rsp_valid_in)
      assert (rid_ok);
    if (!reset && state == LOCKED)
      assert ((valid_g & sent_lanes) == '0);
  end
`endif

endmodule

// File: tb/tb_dcache_req_arbiter.sv
// Self-checking bench for dcache_req_arbiter: directed scenarios plus a
// randomized run compared against a request-level round-robin model.
module tb_dcache_req_arbiter;
  localparam int NR  = 2;
  localparam int NL  = 4;
  localparam int AW  = 30;
  localparam int DW  = 32;
  localparam int TIW = 8;
  localparam int IDB = 1;
  localparam int BEW = DW / 8;
  localparam int TOW = TIW + IDB;

  logic                   clk = 1'b0;
  logic                   reset;
  logic [NR*NL-1:0]       req_valid_in, req_rw_in, req_ready_in;
  logic [NR*NL*AW-1:0]    req_addr_in;
  logic [NR*NL*BEW-1:0]   req_byteen_in;
  logic [NR*NL*DW-1:0]    req_data_in;
  logic [NR*NL*TIW-1:0]   req_tag_in;
  logic [NL-1:0]          req_valid_out, req_rw_out, req_ready_out;
  logic [NL*AW-1:0]       req_addr_out;
  logic [NL*BEW-1:0]      req_byteen_out;
  logic [NL*DW-1:0]       req_data_out;
  logic [NL*TOW-1:0]      req_tag_out;
  logic                   rsp_valid_in, rsp_ready_in;
  logic [NL-1:0]          rsp_tmask_in, rsp_tmask_out;
  logic [NL*DW-1:0]       rsp_data_in, rsp_data_out;
  logic [TOW-1:0]         rsp_tag_in;
  logic [NR-1:0]          rsp_valid_out, rsp_ready_out;
  logic [TIW-1:0]         rsp_tag_out;

  int checks = 0;
  int errors = 0;

  // Model: outstanding lanes and fields per requester, current owner, priority
  logic [NL-1:0]  m_pend [NR];
  logic [NL-1:0]  m_rw   [NR];
  logic [AW-1:0]  m_addr [NR][NL];
  logic [BEW-1:0] m_be   [NR][NL];
  logic [DW-1:0]  m_data [NR][NL];
  logic [TIW-1:0] m_tag  [NR][NL];
  int m_owner;
  int m_prio;

  dcache_req_arbiter #(
    .NUM_REQS(NR), .NUM_LANES(NL), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TAG_IN_WIDTH(TIW)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid_in(req_valid_in), .req_rw_in(req_rw_in), .req_addr_in(req_addr_in),
    .req_byteen_in(req_byteen_in), .req_data_in(req_data_in), .req_tag_in(req_tag_in),
    .req_ready_in(req_ready_in),
    .req_valid_out(req_valid_out), .req_rw_out(req_rw_out), .req_addr_out(req_addr_out),
    .req_byteen_out(req_byteen_out), .req_data_out(req_data_out), .req_tag_out(req_tag_out),
    .req_ready_out(req_ready_out),
    .rsp_valid_in(rsp_valid_in), .rsp_tmask_in(rsp_tmask_in), .rsp_data_in(rsp_data_in),
    .rsp_tag_in(rsp_tag_in), .rsp_ready_in(rsp_ready_in),
    .rsp_valid_out(rsp_valid_out), .rsp_tmask_out(rsp_tmask_out), .rsp_data_out(rsp_data_out),
    .rsp_tag_out(rsp_tag_out), .rsp_ready_out(rsp_ready_out)
  );

  always #5 clk = ~clk;

  task automatic new_req(input int r, input logic [NL-1:0] mask);
    m_pend[r] = mask;
    for (int l = 0; l < NL; l++) begin
      m_rw[r][l]   = 1'($urandom);
      m_addr[r][l] = AW'($urandom);
      m_be[r][l]   = BEW'($urandom);
      m_data[r][l] = $urandom;
      m_tag[r][l]  = TIW'($urandom);
    end
  endtask

  task automatic drive_reqs();
    for (int r = 0; r < NR; r++)
      for (int l = 0; l < NL; l++) begin
        req_valid_in[r*NL+l]               = m_pend[r][l];
        req_rw_in[r*NL+l]                  = m_rw[r][l];
        req_addr_in[(r*NL+l)*AW +: AW]     = m_addr[r][l];
        req_byteen_in[(r*NL+l)*BEW +: BEW] = m_be[r][l];
        req_data_in[(r*NL+l)*DW +: DW]     = m_data[r][l];
        req_tag_in[(r*NL+l)*TIW +: TIW]    = m_tag[r][l];
      end
  endtask

  function automatic int exp_grant();
    if (m_owner >= 0) return (|m_pend[m_owner]) ? m_owner : -1;
    for (int i = 0; i < NR; i++)
      if (|m_pend[(m_prio + i) % NR]) return (m_prio + i) % NR;
    return -1;
  endfunction

  function automatic int obs_grant();
    for (int r = 0; r < NR; r++)
      if (req_ready_in[r*NL +: NL] != '0) return r;
    return -1;
  endfunction

  // Check forwarding for the current cycle, then advance the model across the edge.
  task automatic step_check(input string name, output int g);
    logic [NR*NL-1:0] e_ready;
    logic [NL-1:0]    e_valid, e_rw, left;
    logic [NL*AW-1:0] e_addr;
    logic [NL*BEW-1:0] e_be;
    logic [NL*DW-1:0] e_data;
    logic [NL*TOW-1:0] e_tag;
    g = exp_grant();
    e_ready = '0; e_valid = '0; e_rw = '0; e_addr = '0; e_be = '0; e_data = '0; e_tag = '0;
    if (g >= 0) begin
      e_ready[g*NL +: NL] = req_ready_out;
      e_valid = m_pend[g];
      for (int l = 0; l < NL; l++) begin
        e_rw[l] = m_rw[g][l];
        e_addr[l*AW +: AW]   = m_addr[g][l];
        e_be[l*BEW +: BEW]   = m_be[g][l];
        e_data[l*DW +: DW]   = m_data[g][l];
        e_tag[l*TOW +: TOW]  = {m_tag[g][l], IDB'(g)};
      end
    end
    checks++;
    if (req_ready_in !== e_ready) begin
      errors++;
      $display("FAIL %s req_ready_in got %h want %h", name, req_ready_in, e_ready);
    end
    checks++;
    if (req_valid_out !== e_valid) begin
      errors++;
      $display("FAIL %s req_valid_out got %h want %h", name, req_valid_out, e_valid);
    end
    if (g >= 0) begin
      checks++;
      if ({req_rw_out, req_addr_out, req_byteen_out, req_data_out, req_tag_out} !==
          {e_rw, e_addr, e_be, e_data, e_tag}) begin
        errors++;
        $display("FAIL %s fields got %h want %h", name,
                 {req_rw_out, req_addr_out, req_byteen_out, req_data_out, req_tag_out},
                 {e_rw, e_addr, e_be, e_data, e_tag});
      end
      left = m_pend[g] & ~req_ready_out;
      m_pend[g] = left;
      if (left == '0) begin
        m_owner = -1;
        m_prio  = (g + 1) % NR;
      end else begin
        m_owner = g;
      end
    end else if (m_owner >= 0) begin
      m_prio  = (m_owner + 1) % NR;
      m_owner = -1;
    end
  endtask

  task automatic cycle(input string name, input logic [NL-1:0] rdy, output int g);
    @(negedge clk);
    req_ready_out = rdy;
    drive_reqs();
    #1;
    step_check(name, g);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    for (int r = 0; r < NR; r++) m_pend[r] = '0;
    m_owner = -1;
    m_prio  = 0;
    drive_reqs();
    req_ready_out = '0;
    rsp_valid_in = 1'b0; rsp_tmask_in = '0; rsp_data_in = '0; rsp_tag_in = '0;
    rsp_ready_out = '0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    int g;
    do_reset();
    cycle("reset_idle", 4'hF, g);
    checks++;
    if (rsp_valid_out !== 2'b00 || rsp_ready_in !== 1'b0) begin
      errors++;
      $display("FAIL reset_rsp got valid %b ready %b want 00 0", rsp_valid_out, rsp_ready_in);
    end
  endtask

  task automatic test_single();
    int g;
    do_reset();
    new_req(0, 4'hF);
    cycle("single", 4'hF, g);
    checks++;
    if (req_ready_in !== 8'h0F || req_tag_out[TOW-1:0] !== {m_tag[0][0], 1'b0}) begin
      errors++;
      $display("FAIL single ready %h tag0 %h want 0f %h", req_ready_in, req_tag_out[TOW-1:0],
               {m_tag[0][0], 1'b0});
    end
    new_req(0, 4'hF);
    new_req(1, 4'hF);
    cycle("single_next", 4'hF, g);
    checks++;
    if (req_ready_in !== 8'hF0) begin
      errors++;
      $display("FAIL single_next ready got %h want f0", req_ready_in);
    end
  endtask

  task automatic test_partial();
    int g;
    do_reset();
    new_req(0, 4'hF);
    new_req(1, 4'hF);
    cycle("partial0", 4'b0011, g);
    checks++;
    if (req_ready_in !== 8'h03) begin
      errors++;
      $display("FAIL partial0 ready got %h want 03", req_ready_in);
    end
    cycle("partial1", 4'b1100, g);
    checks++;
    if (req_ready_in !== 8'h0C || req_valid_out !== 4'b1100) begin
      errors++;
      $display("FAIL partial1 ready %h valid %b want 0c 1100", req_ready_in, req_valid_out);
    end
    cycle("partial2", 4'hF, g);
    checks++;
    if (req_ready_in !== 8'hF0) begin
      errors++;
      $display("FAIL partial2 ready got %h want f0", req_ready_in);
    end
  endtask

  task automatic test_round_robin();
    int g, o;
    do_reset();
    new_req(0, 4'hF);
    new_req(1, 4'hF);
    for (int i = 0; i < 4; i++) begin
      cycle("rr", 4'hF, g);
      o = obs_grant();
      checks++;
      if (o != i % 2) begin
        errors++;
        $display("FAIL rr cycle %0d grant got %0d want %0d", i, o, i % 2);
      end
      if (g >= 0 && m_pend[g] == '0) new_req(g, 4'hF);
    end
  endtask

  task automatic test_response();
    @(negedge clk);
    rsp_valid_in = 1'b1; rsp_tag_in = {8'hA5, 1'b1}; rsp_ready_out = 2'b10;
    rsp_tmask_in = 4'b0101; rsp_data_in = {4{$urandom}};
    #1;
    checks++;
    if (rsp_valid_out !== 2'b10 || rsp_tag_out !== 8'hA5 || rsp_ready_in !== 1'b1 ||
        rsp_tmask_out !== 4'b0101 || rsp_data_out !== rsp_data_in) begin
      errors++;
      $display("FAIL rsp_route valid %b tag %h ready %b want 10 a5 1", rsp_valid_out,
               rsp_tag_out, rsp_ready_in);
    end
    rsp_ready_out = 2'b01;
    #1;
    checks++;
    if (rsp_ready_in !== 1'b0) begin
      errors++;
      $display("FAIL rsp_backpressure ready got %b want 0", rsp_ready_in);
    end
    rsp_tag_in = {8'h17, 1'b0};
    #1;
    checks++;
    if (rsp_valid_out !== 2'b01 || rsp_ready_in !== 1'b1 || rsp_tag_out !== 8'h17) begin
      errors++;
      $display("FAIL rsp_id0 valid %b ready %b tag %h want 01 1 17", rsp_valid_out,
               rsp_ready_in, rsp_tag_out);
    end
    rsp_valid_in = 1'b0;
    #1;
    checks++;
    if (rsp_valid_out !== 2'b00) begin
      errors++;
      $display("FAIL rsp_idle valid got %b want 00", rsp_valid_out);
    end
  endtask

  task automatic test_reset_locked();
    int g;
    do_reset();
    new_req(1, 4'hF);
    cycle("rl_lock", 4'b0011, g);
    checks++;
    if (req_ready_in !== 8'h30) begin
      errors++;
      $display("FAIL rl_lock ready got %h want 30", req_ready_in);
    end
    do_reset();
    cycle("rl_after", 4'hF, g);
    checks++;
    if (req_ready_in !== 8'h00) begin
      errors++;
      $display("FAIL rl_after ready got %h want 00", req_ready_in);
    end
    new_req(0, 4'hF);
    new_req(1, 4'hF);
    cycle("rl_ptr0", 4'hF, g);
    checks++;
    if (req_ready_in !== 8'h0F) begin
      errors++;
      $display("FAIL rl_ptr0 ready got %h want 0f", req_ready_in);
    end
  endtask

  task automatic test_concurrency();
    int g;
    do_reset();
    new_req(0, 4'hF);
    rsp_valid_in = 1'b1; rsp_tag_in = {8'h3C, 1'b1}; rsp_ready_out = 2'b10;
    cycle("conc", 4'hF, g);
    checks++;
    if (req_ready_in !== 8'h0F || rsp_valid_out !== 2'b10 || rsp_ready_in !== 1'b1 ||
        rsp_tag_out !== 8'h3C) begin
      errors++;
      $display("FAIL conc ready %h rsp_valid %b rsp_ready %b tag %h want 0f 10 1 3c",
               req_ready_in, rsp_valid_out, rsp_ready_in, rsp_tag_out);
    end
    rsp_valid_in = 1'b0;
  endtask

  task automatic test_random();
    int g, id;
    logic [NR-1:0] e_rv;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      for (int r = 0; r < NR; r++)
        if (m_pend[r] == '0 && $urandom_range(0, 2) != 0)
          new_req(r, NL'($urandom_range(1, 15)));
      id = int'($urandom_range(0, NR - 1));
      rsp_valid_in  = 1'($urandom);
      rsp_tag_in    = {TIW'($urandom), IDB'(id)};
      rsp_ready_out = NR'($urandom);
      cycle("random", NL'($urandom_range(0, 15)), g);
      e_rv = rsp_valid_in ? NR'(1 << id) : '0;
      checks++;
      if (rsp_valid_out !== e_rv || rsp_ready_in !== rsp_ready_out[id] ||
          rsp_tag_out !== rsp_tag_in[TOW-1:IDB]) begin
        errors++;
        $display("FAIL random_rsp cycle %0d valid %b ready %b want %b %b", i, rsp_valid_out,
                 rsp_ready_in, e_rv, rsp_ready_out[id]);
      end
    end
    rsp_valid_in = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    req_ready_out = '0;
    rsp_valid_in = 1'b0; rsp_tmask_in = '0; rsp_data_in = '0; rsp_tag_in = '0;
    rsp_ready_out = '0;
    for (int r = 0; r < NR; r++) begin
      m_pend[r] = '0;
      new_req(r, '0);
    end
    m_owner = -1;
    m_prio  = 0;
    drive_reqs();
    test_reset();
    test_single();
    test_partial();
    test_round_robin();
    test_response();
    test_reset_locked();
    test_concurrency();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dcache_req_arbiter.md
Name: dcache_req_arbiter

Overview:
- Shares one multi-lane D$ request/response port between NUM_REQS requesters, e.g. the load/store unit plus a texture or raster unit.
- Requests are granted round-robin, and a grant is held until every valid lane of that request has been accepted (partial-ready lanes).
- The arbiter appends the requester ID to the outgoing tag and uses it to route each response back to its owner.
- It sits between the requesters and the core D$ front end.

Parameters:
- NUM_REQS, 2, number of requesters; must be ≥2.
- NUM_LANES, 4, lanes per request (matches NUM_THREADS).
- ADDR_WIDTH, 30, word address width.
- DATA_WIDTH, 32, lane data width; byteen width is DATA_WIDTH/8.
- TAG_IN_WIDTH, 8, requester-side tag width.
- Derived: ID_BITS = clog2(NUM_REQS); TAG_OUT_WIDTH = TAG_IN_WIDTH + ID_BITS.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous active-high reset.
- req_valid_in  in  NUM_REQS*NUM_LANES  per-requester, per-lane request valid.
- req_rw_in  in  NUM_REQS*NUM_LANES  1 = write.
- req_addr_in  in  NUM_REQS*NUM_LANES*ADDR_WIDTH  word address.
- req_byteen_in  in  NUM_REQS*NUM_LANES*DATA_WIDTH/8  byte enables.
- req_data_in  in  NUM_REQS*NUM_LANES*DATA_WIDTH  write data.
- req_tag_in  in  NUM_REQS*NUM_LANES*TAG_IN_WIDTH  requester tag.
- req_ready_in  out  NUM_REQS*NUM_LANES  per-lane accept.
- req_valid_out / req_rw_out / req_addr_out / req_byteen_out / req_data_out  out  NUM_LANES*(…)  to D$.
- req_tag_out  out  NUM_LANES*TAG_OUT_WIDTH  lane tag = {req_tag_in, grant_id}.
- req_ready_out  in  NUM_LANES  D$ per-lane ready.
- rsp_valid_in  in  1  D$ response valid.
- rsp_tmask_in  in  NUM_LANES  lanes carried by the response.
- rsp_data_in  in  NUM_LANES*DATA_WIDTH  response data.
- rsp_tag_in  in  TAG_OUT_WIDTH  response tag.
- rsp_ready_in  out  1  response accept to D$.
- rsp_valid_out  out  NUM_REQS  routed response valid.
- rsp_tmask_out  out  NUM_LANES  broadcast to all requesters.
- rsp_data_out  out  NUM_LANES*DATA_WIDTH  broadcast.
- rsp_tag_out  out  TAG_IN_WIDTH  rsp_tag_in[TAG_OUT_WIDTH-1:ID_BITS].
- rsp_ready_out  in  NUM_REQS  requester response ready.

Behaviour:
- Requester r is active when |req_valid_in[r] is set.
- State: IDLE or LOCKED, plus a priority pointer rr_ptr (ID_BITS) and a grant_id register.
- Reset values: state=IDLE, rr_ptr=0, grant_id=0. All outputs depend only on inputs and state: with no valid inputs, every valid/ready output is 0.
- IDLE:
  - Combinationally select the first active requester at or after rr_ptr, wrapping modulo NUM_REQS.
  - The selection is the effective grant this cycle (zero-latency forward).
- LOCKED:
  - The effective grant is grant_id; no other requester is considered.
- Forwarding:
  - req_*_out[l] take the granted requester's lane l.
  - req_ready_in[g][l] = req_ready_out[l]; req_ready_in is 0 for every non-granted requester.
  - req_tag_out[l] = {req_tag_in[g][l], g}.
- Completion condition: every lane l with req_valid_in[g][l]=1 also has req_ready_out[l]=1 this cycle.
- From IDLE with a grant:
  - On completion: stay IDLE, rr_ptr ← g+1 (wrap).
  - Otherwise: go LOCKED, grant_id ← g.
- From LOCKED:
  - On completion, or if the requester drops all valids: go IDLE, rr_ptr ← grant_id+1 (wrap).
  - Otherwise stay LOCKED.
- Requester contract:
  - Once a lane is accepted, the requester deasserts that lane's valid.
  - It holds the fields of unsent lanes stable.
  - A new request from the same requester starts only after completion.
- Fairness: a requester that is continuously active is granted within NUM_REQS grants.
- Response path (purely combinational, no buffering):
  - rid = rsp_tag_in[ID_BITS-1:0].
  - rsp_valid_out[r] = rsp_valid_in && (r == rid).
  - rsp_ready_in = rsp_ready_out[rid].
  - rid ≥ NUM_REQS is illegal: simulation assertion, rsp_ready_in=1, and the response is dropped.
- Requests and responses are independent; the same cycle may carry a response to one requester while granting another.
- Reset mid-LOCKED: go IDLE with rr_ptr=0 on the next edge; partially sent requests are not resumed.
- Not synthesized: assertion that a LOCKED requester does not raise valid on an already-accepted lane.

Test Plan:
- Single requester: NUM_REQS=2, NUM_LANES=4, r0 valid=4'b1111, req_ready_out=4'b1111 → all lanes forwarded in the same cycle; req_tag_out lane0 = {tag,1'b0}; state stays IDLE; rr_ptr=1.
- Partial ready: r0 valid=4'b1111, ready=4'b0011 on cycle 0 → LOCKED. Then r0 valid=4'b1100, ready=4'b1100 → IDLE; r1 (valid throughout) sees req_ready_in=0 until cycle 2, then is granted.
- Round-robin: both requesters continuously valid with full ready → grants alternate r0,r1,r0,r1 over 4 cycles.
- Response routing: rsp_tag_in={8'hA5,1'b1}, rsp_valid_in=1, rsp_ready_out=2'b10 → rsp_valid_out=2'b10, rsp_tag_out=8'hA5, rsp_ready_in=1. With rsp_ready_out=2'b01 → rsp_ready_in=0.
- Reset while LOCKED (r1 granted, 2 lanes pending) → after one reset cycle: IDLE, rr_ptr=0, all req_ready_in=0 with no valids applied.
- Concurrency: r0 request fires while a response with tag id=1 is returned → both complete in the same cycle, with no interaction between them.
